// File: rtl/tone_pkg.sv
// Shared tone package: note centre table used by both the tone generator and the
// frequency decoder, the "no note" code, the decoder FSM state encoding and a small
// absolute-difference helper for the note matcher.
package tone_pkg;

    localparam int unsigned NUM_NOTES = 24;
    localparam logic [4:0]  NO_NOTE   = 5'd31;

    // Equal-tempered centres in Hz, C4 .. B5 (A4 = 440 at index 9).
    localparam int unsigned NOTE_HZ [0:NUM_NOTES-1] = '{
        262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
        523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988
    };

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGate   = 2'd1,
        StLatch  = 2'd2,
        StDecode = 2'd3
    } tone_state_e;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/note_matcher.sv
// Combinational note matcher: maps a frequency in Hz onto the shared note table.
// Ports:
//   freq_hz   in   32  frequency to classify
//   note_hit  out  1   freq_hz within TOL_HZ of some table centre
//   note_idx  out  5   lowest matching table index, NO_NOTE when no match
module note_matcher
    import tone_pkg::*;
#(
    parameter int unsigned TOL_HZ = 8
) (
    input  logic [31:0] freq_hz,
    output logic        note_hit,
    output logic [4:0]  note_idx
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        note_hit = 1'b0;
        note_idx = NO_NOTE;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (abs_diff(freq_hz, 32'(NOTE_HZ[i])) <= TOL_HZ) begin
                note_hit = 1'b1;
                note_idx = 5'(i);
            end
        end
    end

endmodule

// File: rtl/tone_freq_decoder.sv
// Tone frequency decoder: counts rising edges of an external square wave over a gate
// window of CLK_HZ >> GATE_SHIFT cycles, scales the count to Hz and matches it against
// the shared note table.
// Optional feature macro: TONE_DEGLITCH_EN adds a stability filter of DEGLITCH_CYC
// cycles between the synchronizer and the edge detector.
// Ports:
//   clk           in   1   system clock
//   reset         in   1   asynchronous active-low reset
//   tone_in       in   1   asynchronous square-wave tone
//   freq_hz       out  32  measured frequency of the last completed window
//   freq_valid    out  1   one-cycle pulse when the result outputs update
//   note_idx      out  5   matched note index, NO_NOTE (31) when unmatched
//   note_hit      out  1   freq_hz is within TOL_HZ of a table entry
//   tone_present  out  1   last window saw at least one edge
//   overflow      out  1   edge counter saturated in the last window
module tone_freq_decoder
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned GATE_SHIFT   = 3,
    parameter int unsigned EDGE_W       = 16,
    parameter int unsigned TOL_HZ       = 8,
    parameter int unsigned DEGLITCH_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic [31:0] freq_hz,
    output logic        freq_valid,
    output logic [4:0]  note_idx,
    output logic        note_hit,
    output logic        tone_present,
    output logic        overflow
);

    localparam int unsigned GateCycles = CLK_HZ >> GATE_SHIFT;
    localparam int unsigned WinW       = (GateCycles > 1) ? $clog2(GateCycles) : 1;
    localparam logic [WinW-1:0] WinLast = WinW'(GateCycles - 1);

    // ------------------------------------------------------------------
    // Input path: synchronizer, optional deglitch, rising-edge detect
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       level;
    logic       level_d_q;
    logic       edge_det;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b00;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], tone_in};
            level_d_q <= level;
        end
    end

`ifdef TONE_DEGLITCH_EN
    localparam int unsigned DgW = $clog2(DEGLITCH_CYC + 1);

    logic [DgW-1:0] dg_cnt_q, dg_cnt_d;
    logic           filt_q, filt_d;

    // The filtered level follows the synchronized input only once the input has
    // disagreed with it for DEGLITCH_CYC consecutive cycles.
    always_comb begin
        filt_d   = filt_q;
        dg_cnt_d = '0;
        if (sync_q[1] != filt_q) begin
            if (dg_cnt_q == DgW'(DEGLITCH_CYC - 1)) begin
                filt_d = sync_q[1];
            end else begin
                dg_cnt_d = dg_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q   <= 1'b0;
            dg_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            dg_cnt_q <= dg_cnt_d;
        end
    end

    assign level = filt_q;
`else
    logic unused_deglitch_cfg;
    assign unused_deglitch_cfg = ^DEGLITCH_CYC;
    assign level = sync_q[1];
`endif

    assign edge_det = level & ~level_d_q;

    // ------------------------------------------------------------------
    // Measurement FSM and counters
    // ------------------------------------------------------------------
    tone_state_e       state_q, state_d;
    logic [WinW-1:0]   win_cnt_q, win_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [EDGE_W-1:0] cnt_lat_q, cnt_lat_d;
    logic              sat_lat_q, sat_lat_d;
    logic              decode_en;

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        cnt_lat_d  = cnt_lat_q;
        sat_lat_d  = sat_lat_q;
        decode_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StGate;
            end
            StGate: begin
                if (edge_det) begin
                    // An edge arriving with the counter already full marks overflow.
                    if (edge_cnt_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                if (win_cnt_q == WinLast) begin
                    win_cnt_d = '0;
                    state_d   = StLatch;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end
            StLatch: begin
                cnt_lat_d  = edge_cnt_q;
                sat_lat_d  = sat_q;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                state_d    = StDecode;
            end
            StDecode: begin
                decode_en = 1'b1;
                state_d   = StGate;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            cnt_lat_q  <= '0;
            sat_lat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            cnt_lat_q  <= cnt_lat_d;
            sat_lat_q  <= sat_lat_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode and result registers
    // ------------------------------------------------------------------
    logic [31:0] freq_calc;
    logic        match_hit;
    logic [4:0]  match_idx;

    assign freq_calc = 32'(cnt_lat_q) << GATE_SHIFT;

    note_matcher #(
        .TOL_HZ (TOL_HZ)
    ) u_note_matcher (
        .freq_hz  (freq_calc),
        .note_hit (match_hit),
        .note_idx (match_idx)
    );

    logic [31:0] freq_hz_q;
    logic        freq_valid_q;
    logic [4:0]  note_idx_q;
    logic        note_hit_q;
    logic        tone_present_q;
    logic        overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            freq_hz_q      <= '0;
            freq_valid_q   <= 1'b0;
            note_idx_q     <= NO_NOTE;
            note_hit_q     <= 1'b0;
            tone_present_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            freq_valid_q <= decode_en;
            if (decode_en) begin
                freq_hz_q      <= freq_calc;
                tone_present_q <= (cnt_lat_q != '0);
                overflow_q     <= sat_lat_q;
                // A saturated count is not a real frequency, so never report a note.
                note_hit_q     <= match_hit & ~sat_lat_q;
                note_idx_q     <= sat_lat_q ? NO_NOTE : match_idx;
            end
        end
    end

    assign freq_hz      = freq_hz_q;
    assign freq_valid   = freq_valid_q;
    assign note_idx     = note_idx_q;
    assign note_hit     = note_hit_q;
    assign tone_present = tone_present_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_tone_freq_decoder.sv
// Scoreboard bench for tone_freq_decoder. Stimulus is timed by the bench from reset
// release; each completed window pushes its expected result, and monitors compare
// whenever freq_valid pulses.
module tb_tone_freq_decoder;

    localparam int unsigned CLK_HZ = 32768;
    localparam int unsigned GSHIFT = 3;
    localparam int          N      = 4096;
`ifdef TONE_DEGLITCH_EN
    localparam int          T2_HALF = 8;
`else
    localparam int          T2_HALF = 2;
`endif

    typedef struct {
        logic [31:0] freq;
        logic [4:0]  idx;
        logic        hit;
        logic        present;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tone = 1'b0;
    logic        tone2 = 1'b0;

    logic [31:0] freq_hz, freq_hz2;
    logic        freq_valid, freq_valid2;
    logic [4:0]  note_idx, note_idx2;
    logic        note_hit, note_hit2;
    logic        tone_present, tone_present2;
    logic        overflow, overflow2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int windows_done = 0;
    int pulses1 = 0;
    int pulses2 = 0;
    exp_t exp_q[$];
    exp_t last_e;

    tone_freq_decoder #(
        .CLK_HZ       (CLK_HZ),
        .GATE_SHIFT   (GSHIFT),
        .EDGE_W       (16),
        .TOL_HZ       (8),
        .DEGLITCH_CYC (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tone_in      (tone),
        .freq_hz      (freq_hz),
        .freq_valid   (freq_valid),
        .note_idx     (note_idx),
        .note_hit     (note_hit),
        .tone_present (tone_present),
        .overflow     (overflow)
    );

    tone_freq_decoder #(
        .CLK_HZ       (CLK_HZ),
        .GATE_SHIFT   (GSHIFT),
        .EDGE_W       (4),
        .TOL_HZ       (8),
        .DEGLITCH_CYC (4)
    ) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .tone_in      (tone2),
        .freq_hz      (freq_hz2),
        .freq_valid   (freq_valid2),
        .note_idx     (note_idx2),
        .note_hit     (note_hit2),
        .tone_present (tone_present2),
        .overflow     (overflow2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_freq_hz"}, freq_hz, e.freq);
        check({tag, "_note_idx"}, 32'(note_idx), 32'(e.idx));
        check({tag, "_note_hit"}, 32'(note_hit), 32'(e.hit));
        check({tag, "_tone_present"}, 32'(tone_present), 32'(e.present));
        check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
    endtask

    function automatic exp_t mk(input int freq, input int idx, input bit hit, input bit pres);
        exp_t e;
        e.freq    = 32'(freq);
        e.idx     = 5'(idx);
        e.hit     = hit;
        e.present = pres;
        e.ovf     = 1'b0;
        e.due     = 0;
        return e;
    endfunction

    // One measurement window, aligned to the bench's own cycle count from GATE entry.
    // k rising edges of period p start at cycle 100; glitch selects 2-cycle pulses instead.
    task automatic run_window(input int k, input int p, input bit glitch, input exp_t e,
                              input int abort_at);
        exp_t r;
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            if (glitch) begin
                tone = (c >= 100 && c < 3900 && (c % 50) < 2);
            end else if (c >= 100 && c < 100 + k * p) begin
                tone = ((c - 100) % p) < (p / 2);
            end else begin
                tone = 1'b0;
            end
            if (c == 10) check_outputs("hold", last_e);
            if (c == abort_at) begin
                reset = 1'b0;
                tone  = 1'b0;
                #1;
                r = mk(0, 31, 0, 0);
                check_outputs("abort_reset", r);
                check("abort_reset_freq_valid", 32'(freq_valid), 32'd0);
                repeat (3) @(negedge clk);
                reset  = 1'b1;
                last_e = r;
                return;
            end
            if (c == N + 1) begin
                e.due = cyc + 1;
                exp_q.push_back(e);
                last_e = e;
                windows_done++;
            end
        end
    endtask

    initial begin
        forever begin
            repeat (T2_HALF) @(negedge clk);
            tone2 = ~tone2;
        end
    end

    // Main-instance monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && freq_valid) begin
                pulses1++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_freq_valid: got pulse, expected none (cycle %0d)",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_cycle", 32'(cyc), 32'(e.due));
                    check_outputs("result", e);
                end
            end
        end
    end

    // Saturating-instance monitor: the fast tone always overflows a 4-bit counter.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset && freq_valid2) begin
                pulses2++;
                check("sat_freq_hz", freq_hz2, 32'd120);
                check("sat_overflow", 32'(overflow2), 32'd1);
                check("sat_note_hit", 32'(note_hit2), 32'd0);
                check("sat_note_idx", 32'(note_idx2), 32'd31);
                check("sat_tone_present", 32'(tone_present2), 32'd1);
            end
        end
    end

    initial begin
        exp_t rst_e;
        rst_e  = mk(0, 31, 0, 0);
        last_e = rst_e;

        // Reset held with the tone toggling.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tone = ~tone;
        end
        #1;
        check_outputs("reset", rst_e);
        check("reset_freq_valid", 32'(freq_valid), 32'd0);
        check("reset_sat_note_idx", 32'(note_idx2), 32'd31);
        check("reset_sat_overflow", 32'(overflow2), 32'd0);
        @(negedge clk);
        tone  = 1'b0;
        reset = 1'b1;

        run_window(55, 70, 1'b0, mk(440, 9, 1, 1), -1);
        run_window(0, 70, 1'b0, mk(0, 31, 0, 0), -1);
        run_window(65, 60, 1'b0, mk(520, 12, 1, 1), -1);
        run_window(45, 80, 1'b0, mk(360, 31, 0, 1), -1);
        run_window(50, 70, 1'b0, mk(400, 7, 1, 1), -1);
        run_window(33, 100, 1'b0, mk(264, 0, 1, 1), -1);
        run_window(123, 30, 1'b0, mk(984, 23, 1, 1), -1);
        run_window(55, 70, 1'b0, mk(440, 9, 1, 1), 2000);
        run_window(55, 70, 1'b0, mk(440, 9, 1, 1), -1);
`ifdef TONE_DEGLITCH_EN
        run_window(0, 70, 1'b1, mk(0, 31, 0, 0), -1);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("pulse_count", 32'(pulses1), 32'(windows_done));
        check("sat_pulse_count", 32'(pulses2), 32'(windows_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
